mem_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency unified memory between the instruction-fetch port and the data-memory port of the 16-bit processor.
- Arbitrates between the two ports and sequences each access through issue, wait and complete.
- Returns read data to the requesting port.
- Drives the stall and drain signals that the pipeline control and the halt logic consume.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    localparam int unsigned MEM_LAT_MAX = 4;
    localparam int unsigned CNT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data ports.
// MEM_ARB_RR_EN: alternate on contention using last_port; otherwise dm wins.
module mem_arb_pick (
    input  logic if_req_i,
    input  logic dm_req_i,
    input  logic last_port_i,
    output logic valid_o,
    output logic port_o
);
    import mem_arb_pkg::*;

    // Pick a winner; a lone requester always wins
    always_comb begin
        valid_o = if_req_i | dm_req_i;
        port_o  = PORT_IF;
`ifdef MEM_ARB_RR_EN
        if (if_req_i && dm_req_i) begin
            port_o = ~last_port_i;
        end else if (dm_req_i) begin
            port_o = PORT_DM;
        end
`else
        if (dm_req_i) begin
            port_o = PORT_DM;
        end
`endif
    end

`ifndef MEM_ARB_RR_EN
    logic unused_last_port;
    assign unused_last_port = last_port_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency memory between fetch and data ports.
// Each access runs issue -> wait MEM_LAT -> done; one access in flight.
// MEM_ARB_RR_EN selects round-robin contention instead of fixed dm priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_grant,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_grant,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_dm,
    input  logic              halt_in,
    output logic              drained
);
    import mem_arb_pkg::*;

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cur_port_q, cur_port_d;
    logic             cur_wr_q, cur_wr_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic             last_port;
    logic             pick_valid, pick_port;
    logic             issue;

    mem_arb_pick u_pick (
        .if_req_i    (if_req & ~halt_in),
        .dm_req_i    (dm_req),
        .last_port_i (last_port),
        .valid_o     (pick_valid),
        .port_o      (pick_port)
    );

    // Combinational outputs are gated by rst so everything reads 0 in reset
    assign issue = rst & (state_q == ARB_IDLE) & pick_valid;

`ifdef MEM_ARB_RR_EN
    logic last_port_q, last_port_d;

    // Remember which port was granted most recently
    always_comb begin
        last_port_d = issue ? pick_port : last_port_q;
    end

    // last_port register, starts at fetch so dm wins first contention
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_port_q <= PORT_IF;
        end else begin
            last_port_q <= last_port_d;
        end
    end

    assign last_port = last_port_q;
`else
    assign last_port = PORT_IF;
`endif

    // Next-state: issue, count latency, capture read data, finish
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_port_d = cur_port_q;
        cur_wr_d   = cur_wr_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (issue) begin
                    state_d    = ARB_BUSY;
                    cnt_d      = CNT_W'(1);
                    cur_port_d = pick_port;
                    cur_wr_d   = (pick_port == PORT_DM) & dm_wr;
                end
            end
            ARB_BUSY: begin
                if (cnt_q == LAT_C) begin
                    state_d = ARB_DONE;
                    cnt_d   = '0;
                    if (!cur_wr_q) begin
                        if (cur_port_q == PORT_DM) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State register; reset discards any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            cnt_q      <= '0;
            cur_port_q <= PORT_IF;
            cur_wr_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_port_q <= cur_port_d;
            cur_wr_q   <= cur_wr_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Memory strobe, grants, done pulses and pipeline handshakes
    always_comb begin
        if_grant  = issue & (pick_port == PORT_IF);
        dm_grant  = issue & (pick_port == PORT_DM);
        mem_en    = issue;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue) begin
            if (pick_port == PORT_DM) begin
                mem_wr    = dm_wr;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
            end else begin
                mem_addr  = if_addr;
            end
        end
        if_done  = (state_q == ARB_DONE) & (cur_port_q == PORT_IF);
        dm_done  = (state_q == ARB_DONE) & (cur_port_q == PORT_DM);
        if_rdata = if_rdata_q;
        dm_rdata = dm_rdata_q;
        stall_if = rst & if_req & ~if_done;
        stall_dm = rst & dm_req & ~dm_done;
        drained  = rst & halt_in & (state_q == ARB_IDLE) & ~dm_req;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a schedule-level reference model. Honours MEM_ARB_RR_EN.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned LAT = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_wr = 1'b0, halt_in = 1'b0;
    logic [15:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic        if_grant, if_done, dm_grant, dm_done;
    logic        mem_en, mem_wr, stall_if, stall_dm, drained;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant),
        .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_grant(dm_grant), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_dm(stall_dm),
        .halt_in(halt_in), .drained(drained)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-latency memory: data appears exactly LAT cycles after issue,
    // random garbage in every other cycle.
    bit [15:0]   mem [0:65535];
    bit          pend_v   = 1'b0;
    int          pend_due = 0;
    logic [15:0] pend_d   = '0;

    always @(negedge clk) begin
        if (!rst) begin
            pend_v = 1'b0;
        end else if (mem_en) begin
            if (mem_wr) begin
                mem[mem_addr] = mem_wdata;
            end else begin
                pend_v   = 1'b1;
                pend_due = cyc + int'(LAT);
                pend_d   = mem[mem_addr];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        mem_rdata = (pend_v && cyc == pend_due) ? pend_d : 16'($urandom);
    end

    function automatic logic [72:0] all_outs();
        return {if_grant, if_done, if_rdata, dm_grant, dm_done, dm_rdata,
                mem_en, mem_wr, mem_addr, mem_wdata, stall_if, stall_dm, drained};
    endfunction

    task automatic drive_idle();
        if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0; halt_in = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive_idle();
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [72:0] o;
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b1; dm_req = 1'b1; halt_in = 1'b1; dm_wr = 1'b1;
        if_addr = 16'h1234; dm_addr = 16'h4321; dm_wdata = 16'hFFFF;
        #2;
        o = all_outs();
        checks++;
        if (o !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h want=0", o);
        end
        @(posedge clk); #1;
        drive_idle(); halt_in = 1'b1; rst = 1'b1;
        #2;
        checks++;
        if (drained !== 1'b1) begin
            failures++; $display("FAIL reset_idle_drained got=%b want=1", drained);
        end
        checks++;
        if ({if_rdata, dm_rdata} !== 32'h0) begin
            failures++; $display("FAIL reset_rdata got=%h want=0", {if_rdata, dm_rdata});
        end
        idle_cycles(2);
    endtask

    task automatic test_single_fetch();
        for (int c = 0; c <= int'(LAT) + 2; c++) begin
            @(posedge clk); #1;
            if_req  = (c <= int'(LAT) + 1);
            if_addr = 16'h0010;
            #2;
            checks++;
            if ({if_grant, dm_grant, mem_en} !== {c == 0, 1'b0, c == 0}) begin
                failures++;
                $display("FAIL fetch_grant c=%0d got=%b want=%b", c,
                         {if_grant, dm_grant, mem_en}, {c == 0, 1'b0, c == 0});
            end
            if (c == 0) begin
                checks++;
                if ({mem_addr, mem_wr} !== {16'h0010, 1'b0}) begin
                    failures++;
                    $display("FAIL fetch_issue got=%h/%b want=0010/0", mem_addr, mem_wr);
                end
            end
            checks++;
            if (if_done !== (c == int'(LAT) + 1)) begin
                failures++; $display("FAIL fetch_done c=%0d got=%b", c, if_done);
            end
            checks++;
            if (stall_if !== (c <= int'(LAT))) begin
                failures++; $display("FAIL fetch_stall c=%0d got=%b", c, stall_if);
            end
            if (c == int'(LAT) + 1) begin
                checks++;
                if (if_rdata !== 16'hABCD) begin
                    failures++; $display("FAIL fetch_rdata got=%h want=abcd", if_rdata);
                end
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_contention();
        logic [3:0] e;
        int         p;
        p = int'(LAT) + 2;
        for (int c = 0; c <= 2 * p; c++) begin
            @(posedge clk); #1;
            dm_req = (c <= p - 1); dm_wr = 1'b0; dm_addr = 16'h0200;
            if_req = (c <= 2 * p - 1); if_addr = 16'h0020;
            #2;
            e = {c == p, c == 0, c == 2 * p - 1, c == p - 1};
            checks++;
            if ({if_grant, dm_grant, if_done, dm_done} !== e) begin
                failures++;
                $display("FAIL contention c=%0d got=%b want=%b", c,
                         {if_grant, dm_grant, if_done, dm_done}, e);
            end
            if (c == p - 1) begin
                checks++;
                if (dm_rdata !== 16'h0BEE) begin
                    failures++; $display("FAIL contention_dm_rdata got=%h want=0bee", dm_rdata);
                end
            end
            if (c == 2 * p - 1) begin
                checks++;
                if (if_rdata !== 16'h5A5A) begin
                    failures++; $display("FAIL contention_if_rdata got=%h want=5a5a", if_rdata);
                end
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_store();
        logic [33:0] e;
        for (int c = 0; c <= int'(LAT) + 2; c++) begin
            @(posedge clk); #1;
            dm_req = (c <= int'(LAT) + 1); dm_wr = 1'b1;
            dm_addr = 16'h0300; dm_wdata = 16'h1234;
            #2;
            e = (c == 0) ? {1'b1, 1'b1, 16'h0300, 16'h1234} : 34'h0;
            checks++;
            if ({mem_en, mem_wr, mem_addr, mem_wdata} !== e) begin
                failures++;
                $display("FAIL store_mem c=%0d got=%h want=%h", c,
                         {mem_en, mem_wr, mem_addr, mem_wdata}, e);
            end
            checks++;
            if (dm_done !== (c == int'(LAT) + 1)) begin
                failures++; $display("FAIL store_done c=%0d got=%b", c, dm_done);
            end
            checks++;
            if (dm_rdata !== 16'h0BEE) begin
                failures++; $display("FAIL store_rdata_kept c=%0d got=%h want=0bee", c, dm_rdata);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_halt();
        for (int c = 0; c <= int'(LAT) + 8; c++) begin
            @(posedge clk); #1;
            if_req = 1'b1; if_addr = 16'h0010; halt_in = (c >= 1);
            #2;
            checks++;
            if ({if_grant, if_done, drained} !==
                {c == 0, c == int'(LAT) + 1, c >= int'(LAT) + 2}) begin
                failures++;
                $display("FAIL halt c=%0d got=%b want=%b", c, {if_grant, if_done, drained},
                         {c == 0, c == int'(LAT) + 1, c >= int'(LAT) + 2});
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        logic [72:0] o;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0010;
        #2;
        checks++;
        if (if_grant !== 1'b1) begin
            failures++; $display("FAIL rstmid_grant got=%b want=1", if_grant);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        o = all_outs();
        checks++;
        if (o !== '0) begin
            failures++; $display("FAIL rstmid_outputs got=%h want=0", o);
        end
        @(posedge clk); #1;
        drive_idle(); rst = 1'b1;
        for (int c = 0; c <= int'(LAT) + 3; c++) begin
            @(posedge clk); #1;
            drive_idle();
            #2;
            checks++;
            if ({if_done, dm_done, if_rdata} !== 18'h0) begin
                failures++;
                $display("FAIL rstmid_no_done c=%0d got=%b%b/%h", c, if_done, dm_done, if_rdata);
            end
        end
        for (int c = 0; c <= int'(LAT) + 1; c++) begin
            @(posedge clk); #1;
            dm_req = 1'b1; dm_addr = 16'h0200;
            #2;
            checks++;
            if ({dm_grant, dm_done} !== {c == 0, c == int'(LAT) + 1}) begin
                failures++;
                $display("FAIL rstmid_idle_grant c=%0d got=%b%b", c, dm_grant, dm_done);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        int         p, k, ph;
        bit         dm_turn;
        logic [3:0] e;
        do_reset();
        p = int'(LAT) + 2;
        for (int c = 0; c < 4 * p; c++) begin
            @(posedge clk); #1;
            if_req = 1'b1; if_addr = 16'h0020;
            dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0200;
            #2;
            k  = c / p;
            ph = c % p;
            dm_turn = !RR || (k % 2 == 0);
            e = {ph == 0 && !dm_turn, ph == 0 && dm_turn,
                 ph == p - 1 && !dm_turn, ph == p - 1 && dm_turn};
            checks++;
            if ({if_grant, dm_grant, if_done, dm_done} !== e) begin
                failures++;
                $display("FAIL back_to_back c=%0d got=%b want=%b", c,
                         {if_grant, dm_grant, if_done, dm_done}, e);
            end
        end
        idle_cycles(int'(LAT) + 2);
    endtask

    task automatic test_random();
        bit [15:0]   refm [0:7];
        bit          if_p, dm_p, dwr, hlt, cur_dm, cur_st, last_dm, win_dm, e_if, idle;
        logic [15:0] ia, da, dwd, cur_val, exp_ird, exp_drd, e_addr, e_wd;
        logic        e_ig, e_dg, e_en, e_wr, e_id, e_dd, e_drn;
        int          free_at, done_at;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            refm[i] = 16'($urandom);
            mem[16'h0040 + 16'(i)] = refm[i];
        end
        if_p = 0; dm_p = 0; dwr = 0; hlt = 0; cur_dm = 0; cur_st = 0; last_dm = 0;
        ia = 16'h0040; da = 16'h0040; dwd = '0; cur_val = '0;
        exp_ird = '0; exp_drd = '0;
        free_at = 0; done_at = -1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!if_p && $urandom_range(0, 2) == 0) begin
                if_p = 1; ia = 16'h0040 + 16'($urandom_range(0, 7));
            end
            if (!dm_p && $urandom_range(0, 2) == 0) begin
                dm_p = 1; dwr = 1'($urandom_range(0, 1));
                da = 16'h0040 + 16'($urandom_range(0, 7)); dwd = 16'($urandom);
            end
            if ($urandom_range(0, 11) == 0) hlt = ~hlt;
            if_req = if_p; if_addr = ia; halt_in = hlt;
            dm_req = dm_p; dm_wr = dwr; dm_addr = da; dm_wdata = dwd;
            #2;
            e_ig = 0; e_dg = 0; e_en = 0; e_wr = 0; e_addr = '0; e_wd = '0;
            idle = (c >= free_at);
            if (idle) begin
                e_if = if_p && !hlt;
                if (e_if || dm_p) begin
                    win_dm  = dm_p && (!e_if || !RR || !last_dm);
                    last_dm = win_dm;
                    cur_dm  = win_dm;
                    e_en    = 1;
                    done_at = c + int'(LAT) + 1;
                    free_at = c + int'(LAT) + 2;
                    if (win_dm) begin
                        e_dg = 1; e_wr = dwr; e_addr = da; e_wd = dwd; cur_st = dwr;
                        if (dwr) refm[da[2:0]] = dwd;
                        else     cur_val = refm[da[2:0]];
                    end else begin
                        e_ig = 1; e_addr = ia; cur_st = 0; cur_val = refm[ia[2:0]];
                    end
                end
            end
            e_id  = (c == done_at) && !cur_dm;
            e_dd  = (c == done_at) && cur_dm;
            e_drn = hlt && idle && !dm_p;
            if (e_id) exp_ird = cur_val;
            if (e_dd && !cur_st) exp_drd = cur_val;
            checks++;
            if ({if_grant, dm_grant, mem_en, if_done, dm_done, stall_if, stall_dm, drained} !==
                {e_ig, e_dg, e_en, e_id, e_dd, if_p & ~e_id, dm_p & ~e_dd, e_drn}) begin
                failures++;
                $display("FAIL rnd_ctrl c=%0d got=%b want=%b", c,
                         {if_grant, dm_grant, mem_en, if_done, dm_done, stall_if, stall_dm, drained},
                         {e_ig, e_dg, e_en, e_id, e_dd, if_p & ~e_id, dm_p & ~e_dd, e_drn});
            end
            checks++;
            if ({mem_wr, mem_addr, mem_wdata} !== {e_wr, e_addr, e_wd}) begin
                failures++;
                $display("FAIL rnd_mem c=%0d got=%h want=%h", c,
                         {mem_wr, mem_addr, mem_wdata}, {e_wr, e_addr, e_wd});
            end
            checks++;
            if ({if_rdata, dm_rdata} !== {exp_ird, exp_drd}) begin
                failures++;
                $display("FAIL rnd_rdata c=%0d got=%h want=%h", c,
                         {if_rdata, dm_rdata}, {exp_ird, exp_drd});
            end
            if (e_id) if_p = 0;
            if (e_dd) dm_p = 0;
        end
        idle_cycles(int'(LAT) + 2);
    endtask

    initial begin
        mem[16'h0010] = 16'hABCD;
        mem[16'h0020] = 16'h5A5A;
        mem[16'h0200] = 16'h0BEE;
        rst = 1'b0;
        drive_idle();
        test_reset();
        test_single_fetch();
        test_contention();
        test_store();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
